w0rm_core_fetch: RTL and testbench

W0RM_CORE_FETCH -- requirements
Module: w0rm_core_fetch

---
 rtl/w0rm_core_pkg.sv | 16 +
 rtl/w0rm_sync_fifo.sv | 79 +++++++
 rtl/w0rm_core_fetch.sv | 116 +++++++++++
 tb/tb_w0rm_core_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_core_pkg.sv
// Shared defaults for the w0rm core fetch path.
// Holds address/instruction widths, the reset vector and the prefetch entry width.
package w0rm_core_pkg;

    localparam int          DEFAULT_ADDR_WIDTH  = 32;
    localparam int          DEFAULT_INST_WIDTH  = 16;
    localparam logic [31:0] DEFAULT_RESET_ADDR  = 32'h2000_0000;
    localparam int          DEFAULT_FIFO_DEPTH  = 4;
    localparam int          DEFAULT_ENTRY_WIDTH = DEFAULT_INST_WIDTH + DEFAULT_ADDR_WIDTH;

    // Prefetch entry layout is {instruction, address}.
    function automatic int entry_width(input int inst_w, input int addr_w);
        return inst_w + addr_w;
    endfunction

endpackage

// File: rtl/w0rm_sync_fifo.sv
// Register-based synchronous FIFO with flush; head data is valid whenever count is non-zero.
// Flush wins over push/pop; pop on empty is ignored.
module w0rm_sync_fifo
    import w0rm_core_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ENTRY_WIDTH,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/w0rm_core_fetch.sv
// Instruction fetch unit: credit-limited prefetch into a small FIFO, branch redirect,
// and a sticky fault when a request gets no response.
module w0rm_core_fetch
    import w0rm_core_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    INST_WIDTH = DEFAULT_INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(DEFAULT_RESET_ADDR),
    parameter int                    FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_valid_out,
    input  logic [INST_WIDTH-1:0] mem_data_in,
    input  logic                  mem_valid_in,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    localparam int ENTRY_W = entry_width(INST_WIDTH, ADDR_WIDTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
    logic                  inflight_q, inflight_d;
    logic                  drop_q, drop_d;
    logic                  fault_q, fault_d;

    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [CNT_W:0]        credit_used;
    logic                  issue, resp_live, push, pop;
    logic                  unused_branch_lsb;

    always_comb begin
        credit_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
        issue        = !reset && !branch_valid && !fault_q
                       && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        // A response is only meaningful if no redirect is discarding it.
        resp_live    = inflight_q && !drop_q && !branch_valid;
        push         = resp_live && mem_valid_in;
        pop          = dec_valid && dec_ready && !branch_valid;

        fetch_pc_d   = fetch_pc_q;
        req_addr_d   = req_addr_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        inflight_d   = issue;
        drop_d       = branch_valid;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(2);
            req_addr_d = fetch_pc_q;
        end
        if (resp_live && !mem_valid_in) begin
            fault_d      = 1'b1;
            fault_addr_d = req_addr_q;
        end
        if (branch_valid) begin
            fetch_pc_d = {branch_addr[ADDR_WIDTH-1:1], 1'b0};
            fault_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_ADDR;
            req_addr_q   <= '0;
            fault_addr_q <= '0;
            inflight_q   <= 1'b0;
            drop_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            fault_addr_q <= fault_addr_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            fault_q      <= fault_d;
        end
    end

    w0rm_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({mem_data_in, req_addr_q}),
        .pop       (pop),
        .flush     (branch_valid),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    assign mem_addr          = fetch_pc_q;
    assign mem_read          = issue;
    assign mem_valid_out     = issue;
    assign dec_valid         = !reset && (fifo_count != '0);
    assign dec_inst          = fifo_head[ENTRY_W-1 -: INST_WIDTH];
    assign dec_pc            = fifo_head[ADDR_WIDTH-1:0];
    assign fault             = fault_q;
    assign fault_addr        = fault_addr_q;
    assign unused_branch_lsb = branch_addr[0];

endmodule

// File: tb/tb_w0rm_core_fetch.sv
// Directed bench for w0rm_core_fetch: a one-cycle-latency memory model returning addr[15:0],
// with an optional withheld address, and hand-computed expectations per step.
module tb_w0rm_core_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_valid_out;
    logic [15:0] mem_data_in;
    logic        mem_valid_in;
    logic        branch_valid;
    logic [31:0] branch_addr;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_inst;
    logic [31:0] dec_pc;
    logic        fault;
    logic [31:0] fault_addr;

    int          errors = 0;
    int          checks = 0;
    logic        withhold_en;
    logic [31:0] withhold_addr;
    int          n_req;

    w0rm_core_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_read      (mem_read),
        .mem_valid_out (mem_valid_out),
        .mem_data_in   (mem_data_in),
        .mem_valid_in  (mem_valid_in),
        .branch_valid  (branch_valid),
        .branch_addr   (branch_addr),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_inst      (dec_inst),
        .dec_pc        (dec_pc),
        .fault         (fault),
        .fault_addr    (fault_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: memory answers the request seen this cycle one cycle later.
    task automatic cyc();
        logic        pend_req;
        logic [31:0] pend_addr;
        pend_req  = (mem_read === 1'b1);
        pend_addr = mem_addr;
        @(posedge clk);
        #1;
        mem_valid_in = pend_req && !(withhold_en && (pend_addr == withhold_addr));
        mem_data_in  = pend_addr[15:0];
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        branch_valid = 1'b0;
        dec_ready    = 1'b0;
        withhold_en  = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        branch_valid  = 1'b1;
        branch_addr   = 32'h1234_5678;
        dec_ready     = 1'b0;
        mem_valid_in  = 1'b0;
        mem_data_in   = '0;
        withhold_en   = 1'b0;
        withhold_addr = '0;

        // Reset state, with a redirect held during reset that must be ignored.
        #1;
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        cyc();
        cyc();
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_addr", fault_addr, 32'h0);
        check("rst_mem_valid_out", 32'(mem_valid_out), 32'd0);
        check("rst_dec_valid2", 32'(dec_valid), 32'd0);

        // Streaming with decoder always ready.
        reset        = 1'b0;
        branch_valid = 1'b0;
        dec_ready    = 1'b1;
        #1;
        check("s_req0_read", 32'(mem_read), 32'd1);
        check("s_req0_vout", 32'(mem_valid_out), 32'd1);
        check("s_req0_addr", mem_addr, 32'h2000_0000);
        check("s_c0_dec_valid", 32'(dec_valid), 32'd0);
        cyc();
        check("s_req1_addr", mem_addr, 32'h2000_0002);
        check("s_c1_dec_valid", 32'(dec_valid), 32'd0);
        cyc();
        check("s_c2_dec_valid", 32'(dec_valid), 32'd1);
        check("s_c2_dec_pc", dec_pc, 32'h2000_0000);
        check("s_c2_dec_inst", 32'(dec_inst), 32'h0000);
        check("s_req2_addr", mem_addr, 32'h2000_0004);
        cyc();
        check("s_c3_dec_pc", dec_pc, 32'h2000_0002);
        check("s_c3_dec_inst", 32'(dec_inst), 32'h0002);
        check("s_req3_addr", mem_addr, 32'h2000_0006);

        // Back-pressure: credit limits to four requests.
        do_reset();
        n_req = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_read === 1'b1) n_req++;
            cyc();
        end
        check("bp_req_count", 32'(n_req), 32'd4);
        check("bp_fifo_count", 32'(dut.fifo_count), 32'd4);
        check("bp_mem_read_low", 32'(mem_read), 32'd0);
        check("bp_dec_pc", dec_pc, 32'h2000_0000);
        dec_ready = 1'b1;
        #1;
        check("bp_pop_no_issue", 32'(mem_read), 32'd0);
        cyc();
        dec_ready = 1'b0;
        #1;
        check("bp_after_pop_count", 32'(dut.fifo_count), 32'd3);
        check("bp_after_pop_read", 32'(mem_read), 32'd1);
        check("bp_after_pop_addr", mem_addr, 32'h2000_0008);
        check("bp_after_pop_dec_pc", dec_pc, 32'h2000_0002);
        cyc();
        check("bp_inflight_no_issue", 32'(mem_read), 32'd0);
        cyc();
        check("bp_refill_count", 32'(dut.fifo_count), 32'd4);

        // Redirect with a request in flight and an entry queued.
        do_reset();
        dec_ready = 1'b1;
        #1;
        cyc();
        cyc();
        branch_valid = 1'b1;
        branch_addr  = 32'h2000_0101;
        #1;
        check("br_no_issue", 32'(mem_read), 32'd0);
        check("br_dec_valid_before", 32'(dec_valid), 32'd1);
        cyc();
        branch_valid = 1'b0;
        mem_valid_in = 1'b1;
        #1;
        check("br_flushed", 32'(dec_valid), 32'd0);
        check("br_count_zero", 32'(dut.fifo_count), 32'd0);
        check("br_new_read", 32'(mem_read), 32'd1);
        check("br_new_addr", mem_addr, 32'h2000_0100);
        check("br_fault_c3", 32'(fault), 32'd0);
        cyc();
        check("br_fault_c4", 32'(fault), 32'd0);
        check("br_dec_valid_c4", 32'(dec_valid), 32'd0);
        cyc();
        check("br_dec_valid_c5", 32'(dec_valid), 32'd1);
        check("br_dec_pc_c5", dec_pc, 32'h2000_0100);
        check("br_dec_inst_c5", 32'(dec_inst), 32'h0100);
        check("br_fault_c5", 32'(fault), 32'd0);

        // Missing response for 0x20000006 raises a sticky fault.
        do_reset();
        withhold_en   = 1'b1;
        withhold_addr = 32'h2000_0006;
        #1;
        for (int i = 0; i < 5; i++) cyc();
        check("flt_set", 32'(fault), 32'd1);
        check("flt_addr", fault_addr, 32'h2000_0006);
        check("flt_no_issue", 32'(mem_read), 32'd0);
        check("flt_count", 32'(dut.fifo_count), 32'd3);
        check("flt_dec_pc0", dec_pc, 32'h2000_0000);
        dec_ready = 1'b1;
        #1;
        check("flt_no_issue_credit", 32'(mem_read), 32'd0);
        cyc();
        check("flt_dec_pc1", dec_pc, 32'h2000_0002);
        cyc();
        check("flt_dec_pc2", dec_pc, 32'h2000_0004);
        check("flt_dec_inst2", 32'(dec_inst), 32'h0004);
        cyc();
        check("flt_drained", 32'(dec_valid), 32'd0);
        check("flt_still_set", 32'(fault), 32'd1);
        check("flt_still_no_issue", 32'(mem_read), 32'd0);
        withhold_en  = 1'b0;
        branch_valid = 1'b1;
        branch_addr  = 32'h2000_0040;
        #1;
        check("flt_br_no_issue", 32'(mem_read), 32'd0);
        cyc();
        branch_valid = 1'b0;
        #1;
        check("flt_cleared", 32'(fault), 32'd0);
        check("flt_resume_read", 32'(mem_read), 32'd1);
        check("flt_resume_addr", mem_addr, 32'h2000_0040);

        // Address wrap at the top of the space.
        do_reset();
        dec_ready    = 1'b1;
        branch_valid = 1'b1;
        branch_addr  = 32'hFFFF_FFFF;
        #1;
        check("wrap_br_no_issue", 32'(mem_read), 32'd0);
        cyc();
        branch_valid = 1'b0;
        #1;
        check("wrap_addr_top", mem_addr, 32'hFFFF_FFFE);
        check("wrap_read_top", 32'(mem_read), 32'd1);
        cyc();
        check("wrap_addr_zero", mem_addr, 32'h0000_0000);
        check("wrap_read_zero", 32'(mem_read), 32'd1);
        cyc();
        check("wrap_dec_pc_top", dec_pc, 32'hFFFF_FFFE);
        check("wrap_dec_inst_top", 32'(dec_inst), 32'h0000_FFFE);
        cyc();
        check("wrap_dec_pc_zero", dec_pc, 32'h0000_0000);
        check("wrap_dec_inst_zero", 32'(dec_inst), 32'h0000_0000);

        // Reset mid-stream with a full FIFO.
        do_reset();
        for (int i = 0; i < 6; i++) cyc();
        check("mr_full_count", 32'(dut.fifo_count), 32'd4);
        check("mr_full_valid", 32'(dec_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mr_rst_read", 32'(mem_read), 32'd0);
        check("mr_rst_vout", 32'(mem_valid_out), 32'd0);
        check("mr_rst_dec_valid", 32'(dec_valid), 32'd0);
        cyc();
        check("mr_dec_valid", 32'(dec_valid), 32'd0);
        check("mr_fault", 32'(fault), 32'd0);
        check("mr_count", 32'(dut.fifo_count), 32'd0);
        reset = 1'b0;
        #1;
        check("mr_first_read", 32'(mem_read), 32'd1);
        check("mr_first_addr", mem_addr, 32'h2000_0000);
        cyc();
        cyc();
        check("mr_first_dec_pc", dec_pc, 32'h2000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
